ex_muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the forwarded operands and decoded M-op held in ID/EX.
- Asserts a stall that freezes IF/ID, ID/EX and the PC until the result is ready.
- Returns the result to the EX result mux on a one-cycle done pulse.

---
 rtl/ex_muldiv_unit_if.sv | 16 +
 rtl/ex_muldiv_unit.sv | 170 +++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_unit_if.sv
// Request/response bundle between the ID/EX stage and the EX multiply/divide unit.
interface ex_muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             flush;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (output start, flush, funct3, op_a, op_b, input stall, done, result);
  modport slave  (input start, flush, funct3, op_a, op_b, output stall, done, result);
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage; holds the pipeline until the result is ready.
// Optional MULDIV_EARLY_OUT_EN: zero-operand multiplies and unsigned divides with op_a < op_b finish in two cycles.
module ex_muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  ex_muldiv_unit_if.slave bus
);
  localparam int unsigned      CW      = $clog2(WIDTH + 1);
  localparam int unsigned      PW      = 2 * WIDTH;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;

  logic [2:0]       f3_q;
  logic             neg_q;
  logic             rneg_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] opnd_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] result_q;

  logic             is_div, a_sgn, b_sgn, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             special;
  logic [WIDTH-1:0] special_res;
  logic             accept, step, last_step, stall_c, done_c;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_add;
  logic [WIDTH:0]   div_sh, div_diff;
  logic [WIDTH-1:0] acc_nxt, lo_nxt;
  logic [PW-1:0]    prod_raw, prod;
  logic [WIDTH-1:0] quo, rem, final_res;

  // Operand sign handling for the incoming op
  always_comb begin
    is_div = bus.funct3[2];
    a_sgn  = is_div ? ~bus.funct3[0] : (bus.funct3 == 3'b001 || bus.funct3 == 3'b010);
    b_sgn  = is_div ? ~bus.funct3[0] : (bus.funct3 == 3'b001);
    a_neg  = a_sgn & bus.op_a[WIDTH-1];
    b_neg  = b_sgn & bus.op_b[WIDTH-1];
    mag_a  = a_neg ? (WIDTH'(0) - bus.op_a) : bus.op_a;
    mag_b  = b_neg ? (WIDTH'(0) - bus.op_b) : bus.op_b;
  end

  // Cases resolved without iterating
  always_comb begin
    special     = 1'b0;
    special_res = '0;
    if (is_div && bus.op_b == '0) begin
      special     = 1'b1;
      special_res = bus.funct3[1] ? bus.op_a : '1;
    end else if (is_div && !bus.funct3[0] && bus.op_a == MIN_NEG && bus.op_b == '1) begin
      special     = 1'b1;
      special_res = bus.funct3[1] ? '0 : MIN_NEG;
    end
`ifdef MULDIV_EARLY_OUT_EN
    else if (!is_div && (bus.op_a == '0 || bus.op_b == '0)) begin
      special     = 1'b1;
      special_res = '0;
    end else if (is_div && bus.funct3[0] && bus.op_a < bus.op_b) begin
      special     = 1'b1;
      special_res = bus.funct3[1] ? bus.op_a : '0;
    end
`endif
  end

  // One radix-2 step: shift-add multiply or restoring divide, plus final sign fix-up
  always_comb begin
    mul_add  = lo_q[0] ? opnd_q : '0;
    mul_sum  = {1'b0, acc_q} + {1'b0, mul_add};
    div_sh   = {acc_q, lo_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, opnd_q};
    if (f3_q[2]) begin
      acc_nxt = div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
      lo_nxt  = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
    end else begin
      acc_nxt = mul_sum[WIDTH:1];
      lo_nxt  = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
    prod_raw = {acc_nxt, lo_nxt};
    prod     = neg_q ? (PW'(0) - prod_raw) : prod_raw;
    quo      = neg_q ? (WIDTH'(0) - lo_nxt) : lo_nxt;
    rem      = rneg_q ? (WIDTH'(0) - acc_nxt) : acc_nxt;
    case (f3_q)
      3'b000:                 final_res = prod[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod[PW-1:WIDTH];
      3'b100, 3'b101:         final_res = quo;
      default:                final_res = rem;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and handshake outputs
  always_comb begin
    state_nxt = state;
    stall_c   = 1'b0;
    done_c    = 1'b0;
    accept    = 1'b0;
    step      = 1'b0;
    last_step = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          accept    = 1'b1;
          stall_c   = 1'b1;
          state_nxt = special ? DONE : CALC;
        end
      end
      CALC: begin
        if (bus.flush) begin
          state_nxt = IDLE;
        end else begin
          stall_c = 1'b1;
          step    = 1'b1;
          if (cnt_q == CW'(1)) begin
            last_step = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        done_c    = ~bus.flush;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f3_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      acc_q    <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      f3_q   <= bus.funct3;
      neg_q  <= a_neg ^ b_neg;
      rneg_q <= a_neg;
      acc_q  <= '0;
      lo_q   <= is_div ? mag_a : mag_b;
      opnd_q <= is_div ? mag_b : mag_a;
      cnt_q  <= CW'(WIDTH);
      if (special) result_q <= special_res;
    end else if (step) begin
      acc_q <= acc_nxt;
      lo_q  <= lo_nxt;
      cnt_q <= cnt_q - CW'(1);
      if (last_step) result_q <= final_res;
    end
  end

  // Reset forces the hold request low even while ID/EX still presents a start
  assign bus.stall  = stall_c & ~rst;
  assign bus.done   = done_c & ~rst;
  assign bus.result = result_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed RV32M vectors, random ops vs. arithmetic model, flush/reset/back-to-back.
module tb_ex_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst;
  int          total = 0;
  int          bad = 0;
  logic [31:0] last_res;

  ex_muldiv_unit_if #(.WIDTH(32)) bus ();
  ex_muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Architectural result of an RV32M op, from plain 64-bit arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f3)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      3'd6: return (b == 0) ? a : 32'(sa % sb);
      default: return (b == 0) ? a : 32'(ua % ub);
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && b == 0) return 2;
    if (f3[2] && !f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
`ifdef MULDIV_EARLY_OUT_EN
    if (!f3[2] && (a == 0 || b == 0)) return 2;
    if (f3[2] && f3[0] && a < b) return 2;
`endif
    return 34;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'($urandom_range(0, 15));
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issue one op (entered 1 time unit after a rising edge) and wait for its done pulse
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int stalls,
                        output bit seen, output logic done_after);
    int cyc;
    bus.start = 1'b1; bus.funct3 = f3; bus.op_a = a; bus.op_b = b;
    cyc = 1; stalls = 0; seen = 1'b0;
    #1;
    while (cyc <= 200) begin
      if (bus.done === 1'b1) begin seen = 1'b1; break; end
      if (bus.stall === 1'b1) stalls++;
      @(posedge clk); #2;
      cyc++;
    end
    lat = cyc;
    res = bus.result;
    bus.start = 1'b0;
    @(posedge clk); #1;
    done_after = bus.done;
    last_res = res;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b1; bus.flush = 1'b0; bus.funct3 = 3'd0; bus.op_a = 32'd3; bus.op_b = 32'd5;
    #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL reset_stall_held_start: got %b expected 0", bus.stall); end
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b expected 0", bus.stall); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    total++; if (bus.result !== 32'h0) begin bad++; $display("FAIL reset_result: got %h expected 00000000", bus.result); end
  endtask

  typedef struct packed {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
  } vec_t;

  task automatic test_directed();
    vec_t        v [12];
    logic [31:0] res;
    int          lat, stalls;
    bit          seen;
    logic        da;
    v[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
    v[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    v[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    v[3]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
    v[4]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
    v[5]  = '{3'd5, 32'd100,       32'd7,         32'd14};
    v[6]  = '{3'd7, 32'd100,       32'd7,         32'd2};
    v[7]  = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF};
    v[8]  = '{3'd6, 32'd5,         32'd0,         32'd5};
    v[9]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    v[10] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    v[11] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    for (int i = 0; i < 12; i++) begin
      run_op(v[i].f3, v[i].a, v[i].b, res, lat, stalls, seen, da);
      total++; if (!seen) begin bad++; $display("FAIL dir%0d_timeout: no done within 200 cycles", i); end
      total++; if (res !== v[i].e) begin bad++; $display("FAIL dir%0d_result: got %h expected %h", i, res, v[i].e); end
      total++; if (lat !== exp_lat(v[i].f3, v[i].a, v[i].b)) begin bad++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, exp_lat(v[i].f3, v[i].a, v[i].b)); end
      total++; if (da !== 1'b0) begin bad++; $display("FAIL dir%0d_done_width: got %b expected 0", i, da); end
      if (i == 0) begin
        total++; if (stalls !== 33) begin bad++; $display("FAIL dir0_stall_cycles: got %0d expected 33", stalls); end
      end
      if (i == 7) begin
        total++; if (stalls !== 1) begin bad++; $display("FAIL dir7_stall_cycles: got %0d expected 1", stalls); end
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic [31:0] a, b, e, res;
    int          lat, stalls;
    bit          seen;
    logic        da;
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      e  = ref_model(f3, a, b);
      run_op(f3, a, b, res, lat, stalls, seen, da);
      total++; if (res !== e) begin bad++; $display("FAIL rnd%0d_result f3=%0d a=%h b=%h: got %h expected %h", i, f3, a, b, res, e); end
      total++; if (lat !== exp_lat(f3, a, b)) begin bad++; $display("FAIL rnd%0d_latency: got %0d expected %0d", i, lat, exp_lat(f3, a, b)); end
      total++; if (da !== 1'b0) begin bad++; $display("FAIL rnd%0d_done_width: got %b expected 0", i, da); end
    end
  endtask

  task automatic test_flush();
    logic [31:0] prev, res;
    int          lat, stalls, extra;
    bit          seen;
    logic        da;
    run_op(3'd7, 32'd1000, 32'd7, res, lat, stalls, seen, da);
    prev = res;
    total++; if (prev !== 32'd6) begin bad++; $display("FAIL flush_prep_result: got %h expected 00000006", prev); end
    bus.start = 1'b1; bus.funct3 = 3'd4; bus.op_a = 32'd1000; bus.op_b = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL flush_calc_stall: got %b expected 1", bus.stall); end
    bus.flush = 1'b1; bus.start = 1'b0;
    #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL flush_same_cycle_stall: got %b expected 0", bus.stall); end
    @(posedge clk); #1;
    bus.flush = 1'b0;
    #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL flush_next_stall: got %b expected 0", bus.stall); end
    total++; if (bus.result !== prev) begin bad++; $display("FAIL flush_result_kept: got %h expected %h", bus.result, prev); end
    extra = 0;
    repeat (40) begin @(posedge clk); #1; if (bus.done === 1'b1) extra++; end
    total++; if (extra !== 0) begin bad++; $display("FAIL flush_no_done: got %0d pulses expected 0", extra); end
    bus.start = 1'b1; bus.flush = 1'b1; bus.funct3 = 3'd0; bus.op_a = 32'd9; bus.op_b = 32'd9;
    #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL flush_start_idle_stall: got %b expected 0", bus.stall); end
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    extra = 0;
    repeat (40) begin @(posedge clk); #1; if (bus.done === 1'b1 || bus.stall === 1'b1) extra++; end
    total++; if (extra !== 0) begin bad++; $display("FAIL flush_start_ignored: got %0d busy cycles expected 0", extra); end
    total++; if (bus.result !== prev) begin bad++; $display("FAIL flush_start_result_kept: got %h expected %h", bus.result, prev); end
    run_op(3'd4, 32'd1000, 32'd3, res, lat, stalls, seen, da);
    total++; if (res !== 32'd333) begin bad++; $display("FAIL flush_restart_result: got %h expected 0000014d", res); end
    total++; if (lat !== 34) begin bad++; $display("FAIL flush_restart_latency: got %0d expected 34", lat); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int          lat, stalls;
    bit          seen;
    logic        da;
    bus.start = 1'b1; bus.funct3 = 3'd0; bus.op_a = 32'h0001_2345; bus.op_b = 32'h0000_6789;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL rstmid_stall: got %b expected 0", bus.stall); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rstmid_done: got %b expected 0", bus.done); end
    total++; if (bus.result !== 32'h0) begin bad++; $display("FAIL rstmid_result: got %h expected 00000000", bus.result); end
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(3'd0, 32'h0001_2345, 32'h0000_6789, res, lat, stalls, seen, da);
    total++; if (res !== ref_model(3'd0, 32'h0001_2345, 32'h0000_6789)) begin bad++; $display("FAIL rstmid_after_result: got %h expected %h", res, ref_model(3'd0, 32'h0001_2345, 32'h0000_6789)); end
    total++; if (lat !== 34) begin bad++; $display("FAIL rstmid_after_latency: got %0d expected 34", lat); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [3];
    logic [31:0] b [3];
    logic [31:0] res [3];
    int          at [3];
    int          n_done;
    for (int i = 0; i < 3; i++) begin
      a[i] = $urandom | 32'h1;
      b[i] = $urandom | 32'h1;
      res[i] = '0;
      at[i] = 0;
    end
    n_done = 0;
    bus.start = 1'b1; bus.funct3 = 3'd0; bus.op_a = a[0]; bus.op_b = b[0];
    for (int c = 1; c <= 150; c++) begin
      #1;
      if (bus.done === 1'b1) begin
        if (n_done < 3) begin res[n_done] = bus.result; at[n_done] = c; end
        n_done++;
        if (n_done < 3) begin bus.op_a = a[n_done]; bus.op_b = b[n_done]; end
        else bus.start = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    total++; if (n_done !== 3) begin bad++; $display("FAIL b2b_done_count: got %0d expected 3", n_done); end
    for (int i = 0; i < 3; i++) begin
      total++; if (res[i] !== ref_model(3'd0, a[i], b[i])) begin bad++; $display("FAIL b2b%0d_result: got %h expected %h", i, res[i], ref_model(3'd0, a[i], b[i])); end
      total++; if (at[i] !== 34 * (i + 1)) begin bad++; $display("FAIL b2b%0d_done_cycle: got %0d expected %0d", i, at[i], 34 * (i + 1)); end
    end
  endtask

  initial begin
    last_res = '0;
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
